// File: rtl/pe_tilde.sv
// pe_tilde: twiddle-free NTT butterfly processing element.
// Computes top = (a + b) mod q and bot = (a - b) mod q with a two-stage,
// free-running pipeline. The modulus is registered alongside its operands
// so a change of q only affects the pair sampled in the same cycle.
module pe_tilde #(
  parameter int DATA_SIZE_ARB = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_SIZE_ARB-1:0] q,
  input  logic [DATA_SIZE_ARB-1:0] data_top_i,
  input  logic [DATA_SIZE_ARB-1:0] data_bot_i,
  output logic [DATA_SIZE_ARB-1:0] ntt_top_o,
  output logic [DATA_SIZE_ARB-1:0] ntt_bot_o
);

  localparam int W = DATA_SIZE_ARB;

  logic [W-1:0] a_r;
  logic [W-1:0] b_r;
  logic [W-1:0] q_r;

  // One extra bit so the sum carry and the difference borrow are kept.
  logic [W:0]   sum_s;
  logic [W:0]   diff_s;
  logic [W-1:0] top_next_s;
  logic [W-1:0] bot_next_s;

  // Stage 1: capture operands and their modulus together.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_r <= {W{1'b0}};
      b_r <= {W{1'b0}};
      q_r <= {W{1'b0}};
    end else begin
      a_r <= data_top_i;
      b_r <= data_bot_i;
      q_r <= q;
    end
  end

  // Stage 2 datapath: conditional subtract on the sum, conditional add on the difference.
  always_comb begin
    sum_s      = {1'b0, a_r} + {1'b0, b_r};
    diff_s     = {1'b0, a_r} - {1'b0, b_r};
    top_next_s = sum_s[W-1:0];
    bot_next_s = diff_s[W-1:0];

    // The sum reaches at most 2q-2, so a single subtraction reduces it.
    if (sum_s >= {1'b0, q_r}) begin
      top_next_s = sum_s[W-1:0] - q_r;
    end else begin
      top_next_s = sum_s[W-1:0];
    end

    // The borrow bit is set exactly when a_r < b_r; adding q folds the
    // negative difference back into [0, q) modulo 2^W.
    if (diff_s[W]) begin
      bot_next_s = diff_s[W-1:0] + q_r;
    end else begin
      bot_next_s = diff_s[W-1:0];
    end
  end

  // Stage 2: output register, no combinational path from inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      ntt_top_o <= {W{1'b0}};
      ntt_bot_o <= {W{1'b0}};
    end else begin
      ntt_top_o <= top_next_s;
      ntt_bot_o <= bot_next_s;
    end
  end

endmodule

// File: tb/tb_pe_tilde.sv
// Self-checking bench for pe_tilde: reset behaviour, a streamed table of
// hand-computed vectors (2-cycle latency, in order, q changes mid-stream)
// and a mid-stream reset sequence.
module tb_pe_tilde;

  localparam int W = 16;

  logic         clk;
  logic         reset;
  logic [W-1:0] q;
  logic [W-1:0] data_top_i;
  logic [W-1:0] data_bot_i;
  logic [W-1:0] ntt_top_o;
  logic [W-1:0] ntt_bot_o;

  int n_tests;
  int n_fail;

  pe_tilde #(.DATA_SIZE_ARB(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .q          (q),
    .data_top_i (data_top_i),
    .data_bot_i (data_bot_i),
    .ntt_top_o  (ntt_top_o),
    .ntt_bot_o  (ntt_bot_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] top;
    logic [W-1:0] bot;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [W-1:0] got_top,
                       input logic [W-1:0] got_bot, input logic [W-1:0] exp_top,
                       input logic [W-1:0] exp_bot);
    n_tests++;
    if (got_top !== exp_top || got_bot !== exp_bot) begin
      n_fail++;
      $display("FAIL %s: got top=%0d bot=%0d, expected top=%0d bot=%0d",
               name, got_top, got_bot, exp_top, exp_bot);
    end
  endtask

  task automatic drive(input logic [W-1:0] qv, input logic [W-1:0] av,
                       input logic [W-1:0] bv);
    q          = qv;
    data_top_i = av;
    data_bot_i = bv;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;

    vecs[0]  = '{16'd7681,  16'd1147,  16'd2963,  16'd4110,  16'd5865};
    vecs[1]  = '{16'd7681,  16'd7000,  16'd1000,  16'd319,   16'd6000};
    vecs[2]  = '{16'd7681,  16'd7680,  16'd7680,  16'd7679,  16'd0};
    vecs[3]  = '{16'd7681,  16'd0,     16'd1,     16'd1,     16'd7680};
    vecs[4]  = '{16'd65521, 16'd65520, 16'd65520, 16'd65519, 16'd0};
    vecs[5]  = '{16'd12289, 16'd12000, 16'd5000,  16'd4711,  16'd7000};
    vecs[6]  = '{16'd12289, 16'd100,   16'd12288, 16'd99,    16'd101};
    vecs[7]  = '{16'd7681,  16'd0,     16'd0,     16'd0,     16'd0};
    vecs[8]  = '{16'd12289, 16'd6144,  16'd6145,  16'd0,     16'd12288};
    vecs[9]  = '{16'd7681,  16'd3840,  16'd3840,  16'd7680,  16'd0};
    vecs[10] = '{16'd3,     16'd2,     16'd1,     16'd0,     16'd1};
    vecs[11] = '{16'd3,     16'd1,     16'd2,     16'd0,     16'd2};
    vecs[12] = '{16'd7681,  16'd8000,  16'd0,     16'd319,   16'd8000};
    vecs[13] = '{16'd65521, 16'd1,     16'd65520, 16'd0,     16'd2};

    // Reset held for 5 cycles with arbitrary inputs.
    reset = 1'b1;
    drive(16'd1234, 16'd4321, 16'd999);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("reset_hold_%0d", i), ntt_top_o, ntt_bot_o, 16'd0, 16'd0);
      drive(16'(16'd100 + i), 16'(16'd50 + i), 16'(16'd77 + i));
    end

    // Release with the basic vector held constant.
    reset = 1'b0;
    drive(16'd7681, 16'd1147, 16'd2963);
    @(negedge clk);
    check("release_edge1", ntt_top_o, ntt_bot_o, 16'd0, 16'd0);
    @(negedge clk);
    check("release_edge2", ntt_top_o, ntt_bot_o, 16'd4110, 16'd5865);
    @(negedge clk);
    check("basic_hold", ntt_top_o, ntt_bot_o, 16'd4110, 16'd5865);

    // Streamed table: a new pair every cycle, result 2 edges later.
    for (int i = 0; i < NV + 2; i++) begin
      if (i >= 2) begin
        check($sformatf("stream_%0d", i - 2), ntt_top_o, ntt_bot_o,
              vecs[i-2].top, vecs[i-2].bot);
      end
      if (i < NV) begin
        drive(vecs[i].q, vecs[i].a, vecs[i].b);
      end else begin
        drive(16'd7681, 16'd0, 16'd0);
      end
      @(negedge clk);
    end

    // Mid-stream reset: pairs A and B are in flight when reset hits.
    drive(16'd7681, 16'd7000, 16'd1000);     // A
    @(negedge clk);
    drive(16'd12289, 16'd12000, 16'd5000);   // B
    @(negedge clk);
    reset = 1'b1;
    drive(16'd7681, 16'd1147, 16'd2963);     // ignored
    @(negedge clk);
    check("midrst_asserted", ntt_top_o, ntt_bot_o, 16'd0, 16'd0);
    reset = 1'b0;
    drive(16'd12289, 16'd100, 16'd12288);    // D
    @(negedge clk);
    check("midrst_edge1", ntt_top_o, ntt_bot_o, 16'd0, 16'd0);
    drive(16'd3, 16'd1, 16'd2);              // E
    @(negedge clk);
    check("midrst_D", ntt_top_o, ntt_bot_o, 16'd99, 16'd101);
    drive(16'd7681, 16'd0, 16'd1);
    @(negedge clk);
    check("midrst_E", ntt_top_o, ntt_bot_o, 16'd0, 16'd2);
    @(negedge clk);
    check("midrst_F", ntt_top_o, ntt_bot_o, 16'd1, 16'd7680);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
